// File: rtl/regfile_sweep.sv
// regfile_sweep: two-read, one-write register file with register 0 tied to zero.
// A synchronous reset starts a sweep that clears one register per cycle, so the
// storage array needs no parallel reset and can map onto plain memory.
// Busy is high for the whole sweep. While it is high, reads return zero and
// writes are ignored.
module regfile_sweep #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int BYPASS    = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic                 RegWrite,
    output logic                 Busy
);

    localparam int NREGS = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_BITS-1:0] PTR_FIRST = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] PTR_LAST  = ADDR_BITS'(NREGS - 1);

    typedef enum logic {
        SWEEP,
        READY
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic                   busy_q, busy_d;

    logic [WIDTH-1:0]       mem [NREGS];

    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [WIDTH-1:0]       mem_wdata;

    logic                   bypass1;
    logic                   bypass2;

    // Next-state logic: advance the clear sweep, or accept user writes once ready.
    // A Reset edge never writes the array; the register update restarts the sweep.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = ADDR_ZERO;
        mem_wdata = '0;
        if (!Reset) begin
            case (state_q)
                SWEEP: begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    ptr_d     = ptr_q + PTR_FIRST;
                    if (ptr_q == PTR_LAST) begin
                        state_d = READY;
                        busy_d  = 1'b0;
                    end
                end
                READY: begin
                    if (RegWrite && (WriteRegister != ADDR_ZERO)) begin
                        mem_we    = 1'b1;
                        mem_waddr = WriteRegister;
                        mem_wdata = WriteData;
                    end
                end
                default: begin
                    state_d = SWEEP;
                    ptr_d   = PTR_FIRST;
                    busy_d  = 1'b1;
                end
            endcase
        end
    end

    // Sweep state machine with a synchronous restart on Reset; Busy is registered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SWEEP;
            ptr_q   <= PTR_FIRST;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Single write port into the storage array; it has no reset of its own.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Same-cycle forwarding of WriteData, only when the BYPASS build option is set.
    always_comb begin
        bypass1 = (BYPASS != 0) && (state_q == READY) && RegWrite &&
                  (WriteRegister != ADDR_ZERO) && (WriteRegister == ReadRegister1);
        bypass2 = (BYPASS != 0) && (state_q == READY) && RegWrite &&
                  (WriteRegister != ADDR_ZERO) && (WriteRegister == ReadRegister2);
    end

    // Asynchronous reads: zero during the sweep or for register 0, else array or bypass.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (!busy_q && (ReadRegister1 != ADDR_ZERO)) begin
            ReadData1 = bypass1 ? WriteData : mem[ReadRegister1];
        end
        if (!busy_q && (ReadRegister2 != ADDR_ZERO)) begin
            ReadData2 = bypass2 ? WriteData : mem[ReadRegister2];
        end
    end

    assign Busy = busy_q;

endmodule

// File: tb/tb_regfile_sweep.sv
// Testbench for regfile_sweep: one instance without forwarding and one with it.
// Both instances share every input. The reference model treats reset as
// "31 edges of busy, then everything reads zero", and it holds the register
// contents in a plain array.
module tb_regfile_sweep;

   localparam int SWEEP_EDGES = 31;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [4:0]  WriteRegister;
   logic        RegWrite;
   logic [31:0] rd1NoByp, rd2NoByp, rd1Byp, rd2Byp;
   logic        busyNoByp, busyByp;

   int checkCount = 0;
   int passCount  = 0;

   logic [31:0] modelMem [32];
   int          busyLeft;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [10];

   regfile_sweep #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(0)) dutNoByp (
      .Clk(Clk), .Reset(Reset), .ReadData1(rd1NoByp), .ReadData2(rd2NoByp),
      .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .WriteRegister(WriteRegister), .RegWrite(RegWrite), .Busy(busyNoByp)
   );

   regfile_sweep #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1)) dutByp (
      .Clk(Clk), .Reset(Reset), .ReadData1(rd1Byp), .ReadData2(rd2Byp),
      .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .WriteRegister(WriteRegister), .RegWrite(RegWrite), .Busy(busyByp)
   );

   // Free-running clock with a period of 10 time units.
   always #5 Clk = ~Clk;

   // Records one comparison and prints a line if it does not match.
   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
      checkCount++;
      if (act === expv) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
   endtask

   // Returns the expected read value for one port, given the current inputs.
   function automatic logic [31:0] expRead(input logic [4:0] ra, input bit byp);
      if (busyLeft > 0) return 32'd0;
      if (ra == 5'd0) return 32'd0;
      if (byp && RegWrite && (WriteRegister == ra)) return WriteData;
      return modelMem[ra];
   endfunction

   // Drives the inputs, then waits a little so the combinational reads settle.
   task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
      Reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
      ReadRegister1 = r1; ReadRegister2 = r2;
      #1;
   endtask

   // Compares all outputs of both instances against the model.
   task automatic checkOutput(input string tag);
      checkVal({tag, " busy"},     {31'd0, busyNoByp}, {31'd0, busyLeft > 0});
      checkVal({tag, " busyByp"},  {31'd0, busyByp},   {31'd0, busyLeft > 0});
      checkVal({tag, " rd1"},      rd1NoByp, expRead(ReadRegister1, 1'b0));
      checkVal({tag, " rd2"},      rd2NoByp, expRead(ReadRegister2, 1'b0));
      checkVal({tag, " rd1Byp"},   rd1Byp,   expRead(ReadRegister1, 1'b1));
      checkVal({tag, " rd2Byp"},   rd2Byp,   expRead(ReadRegister2, 1'b1));
   endtask

   // Takes one clock edge and updates the model from the inputs that were applied.
   task automatic clockEdge();
      @(posedge Clk);
      if (Reset) begin
         busyLeft = SWEEP_EDGES;
      end else if (busyLeft > 0) begin
         busyLeft--;
         if (busyLeft == 0) foreach (modelMem[i]) modelMem[i] = 32'd0;
      end else if (RegWrite && WriteRegister != 5'd0) begin
         modelMem[WriteRegister] = WriteData;
      end
      #1;
   endtask

   // Counts how many edges Busy stays high after a reset, with a fixed bound.
   task automatic countSweep(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
      int n = 0;
      while (n < 100) begin
         applyStimulus(1'b0, we, wa, wd, 5'(n), 5'(n + 7));
         if (n < 3 || n > 28) checkOutput({tag, " sweep"});
         if (busyNoByp !== 1'b1) break;
         clockEdge();
         n++;
      end
      checkVal({tag, " sweep edges"}, 32'(n), 32'(SWEEP_EDGES));
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd2,  32'd42, 5'd2, 5'd2,  32'd0,  32'd0};
      vecs[1] = '{1'b1, 5'd2,  32'd15, 5'd2, 5'd2,  32'd42, 32'd42};
      vecs[2] = '{1'b0, 5'd2,  32'd30, 5'd2, 5'd2,  32'd15, 32'd15};
      vecs[3] = '{1'b0, 5'd2,  32'd30, 5'd2, 5'd2,  32'd15, 32'd15};
      vecs[4] = '{1'b1, 5'd2,  32'd15, 5'd2, 5'd1,  32'd15, 32'd0};
      vecs[5] = '{1'b0, 5'd2,  32'd15, 5'd2, 5'd1,  32'd15, 32'd0};
      vecs[6] = '{1'b1, 5'd0,  32'd15, 5'd0, 5'd2,  32'd0,  32'd15};
      vecs[7] = '{1'b1, 5'd17, 32'd30, 5'd0, 5'd2,  32'd0,  32'd15};
      vecs[8] = '{1'b0, 5'd0,  32'd0,  5'd0, 5'd17, 32'd0,  32'd30};
      vecs[9] = '{1'b0, 5'd0,  32'd0,  5'd17, 5'd2, 32'd30, 32'd15};

      foreach (modelMem[i]) modelMem[i] = 32'd0;
      busyLeft = SWEEP_EDGES;

      // Initial reset, then the full sweep and a read of every register.
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      clockEdge();
      countSweep("reset1", 1'b0, 5'd0, 32'd0);
      for (int r = 1; r < 32; r++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'(r), 5'(32 - r));
         checkVal("cleared rd1", rd1NoByp, 32'd0);
         checkVal("cleared rd2", rd2NoByp, 32'd0);
      end

      // Directed write/read vectors; expectations are pre-edge values without forwarding.
      foreach (vecs[i]) begin
         applyStimulus(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2);
         checkVal($sformatf("vec%0d rd1", i), rd1NoByp, vecs[i].e1);
         checkVal($sformatf("vec%0d rd2", i), rd2NoByp, vecs[i].e2);
         checkOutput($sformatf("vec%0d", i));
         clockEdge();
      end

      // Forwarding before any clock edge, including the register-0 case.
      applyStimulus(1'b0, 1'b1, 5'd9, 32'd7, 5'd9, 5'd2);
      checkVal("bypass r9",      rd1Byp,   32'd7);
      checkVal("nobypass r9",    rd1NoByp, 32'd0);
      applyStimulus(1'b0, 1'b1, 5'd0, 32'd7, 5'd0, 5'd2);
      checkVal("bypass r0",      rd1Byp,   32'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

      // Mid-sweep write, then a reset pulse that restarts the sweep.
      applyStimulus(1'b0, 1'b1, 5'd5, 32'd123, 5'd5, 5'd0);
      clockEdge();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
      checkVal("r5 preset", rd1NoByp, 32'd123);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
      clockEdge();
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
         clockEdge();
      end
      applyStimulus(1'b0, 1'b1, 5'd5, 32'd99, 5'd5, 5'd5);
      checkOutput("midsweep write");
      clockEdge();
      applyStimulus(1'b1, 1'b1, 5'd5, 32'd99, 5'd5, 5'd5);
      checkOutput("midsweep reset");
      clockEdge();
      countSweep("restart", 1'b1, 5'd5, 32'd99);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
      checkVal("r5 after restart p1", rd1NoByp, 32'd0);
      checkVal("r5 after restart p2", rd2NoByp, 32'd0);

      // Random traffic with occasional resets, checked against the model.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] wa, r1, r2;
         wa = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         r1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         r2 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         applyStimulus(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), wa,
                       $urandom, r1, r2);
         checkOutput($sformatf("rand%0d", i));
         clockEdge();
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
